// File: rtl/mult_pkg.sv
// mult_pkg: shared types and defaults for the MAC datapath.
//   acc_state_t  - accumulator FSM state encoding
//   PROD_W_DEF   - default product width (multiplier result width)
//   ACC_W_DEF    - default accumulator width
//   prod_word_t  - product word shared with the multiplier
package mult_pkg;

  localparam int PROD_W_DEF = 32;
  localparam int ACC_W_DEF  = 40;

  typedef logic [PROD_W_DEF-1:0] prod_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/mult_accumulator_acc_adder.sv
// acc_adder: combinational accumulator adder.
//   acc_i   [ACC_W]  current accumulator
//   prod_i  [PROD_W] unsigned product, zero-extended before the add
//   sum_o   [ACC_W]  next accumulator value
//   carry_o          carry out of bit ACC_W-1
// Build option: MULT_ACC_SAT_EN clamps sum_o to all-ones on carry;
// otherwise the sum wraps modulo 2^ACC_W.
module acc_adder #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              carry_o
);

  logic [ACC_W:0] full_sum;

  assign full_sum = {1'b0, acc_i} + {{(ACC_W+1-PROD_W){1'b0}}, prod_i};
  assign carry_o  = full_sum[ACC_W];

`ifdef MULT_ACC_SAT_EN
  // Once saturated, every further non-zero add carries again, so the
  // value sticks at all-ones for the rest of the block.
  assign sum_o = carry_o ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
  assign sum_o = full_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/mult_accumulator.sv
// mult_accumulator: sums a block of LEN unsigned products and presents
// the block sum over a valid/ready handshake.
//   clk, reset (async active-low), clear (sync abort)
//   start/len       - block request, sampled only in IDLE
//   prod_valid/prod_data/prod_ready - product input handshake
//   sum_valid/sum_data/sum_ready    - block sum output handshake
//   busy            - state != IDLE
//   overflow        - sticky carry-out flag for the current block
// Build option: MULT_ACC_SAT_EN (saturating accumulate, see acc_adder).
//
// state | meaning
// IDLE  | waiting for start
// ACCUM | accepting products, count holds products still expected
// HOLD  | sum_data valid, waiting for sum_ready
module mult_accumulator
  import mult_pkg::*;
#(
  parameter int PROD_W  = PROD_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int MAX_LEN = 16,
  localparam int CNT_W  = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod_data,
  output logic              prod_ready,
  output logic              sum_valid,
  output logic [ACC_W-1:0]  sum_data,
  input  logic              sum_ready,
  output logic              busy,
  output logic              overflow
);

  acc_state_t       state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             carry_d;
  logic             ovf_q;
  logic             prod_ready_q;
  logic             sum_valid_q;
  logic             busy_q;

  acc_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_adder (
    .acc_i   (acc_q),
    .prod_i  (prod_data),
    .sum_o   (acc_d),
    .carry_o (carry_d)
  );

  // Block length as loaded on start; oversize requests clamp to MAX_LEN.
  assign count_d = (len > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : len;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      prod_ready_q <= 1'b0;
      sum_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else if (clear) begin
      // Any handshake coinciding with clear is dropped.
      state_q      <= IDLE;
      acc_q        <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      prod_ready_q <= 1'b0;
      sum_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            if (len == '0) begin
              state_q     <= HOLD;
              sum_valid_q <= 1'b1;
            end else begin
              state_q      <= ACCUM;
              count_q      <= count_d;
              prod_ready_q <= 1'b1;
            end
          end
        end
        ACCUM: begin
          // prod_ready is always high in ACCUM, so prod_valid alone is the handshake.
          if (prod_valid) begin
            acc_q   <= acc_d;
            ovf_q   <= ovf_q | carry_d;
            count_q <= count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
              state_q      <= HOLD;
              prod_ready_q <= 1'b0;
              sum_valid_q  <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (sum_ready) begin
            state_q     <= IDLE;
            sum_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          prod_ready_q <= 1'b0;
          sum_valid_q  <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign prod_ready = prod_ready_q;
  assign sum_valid  = sum_valid_q;
  assign sum_data   = acc_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// Directed bench for mult_accumulator: default-width instance plus a
// 33-bit accumulator instance for the carry-out cases.
module tb_mult_accumulator;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        start;
  logic [4:0]  len;
  logic        prod_valid;
  logic [31:0] prod_data;
  logic        prod_ready;
  logic        sum_valid;
  logic [39:0] sum_data;
  logic        sum_ready;
  logic        busy;
  logic        overflow;

  logic        b_clear;
  logic        b_start;
  logic [4:0]  b_len;
  logic        b_prod_valid;
  logic [31:0] b_prod_data;
  logic        b_prod_ready;
  logic        b_sum_valid;
  logic [32:0] b_sum_data;
  logic        b_sum_ready;
  logic        b_busy;
  logic        b_overflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] exp33;

  mult_accumulator dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .start      (start),
    .len        (len),
    .prod_valid (prod_valid),
    .prod_data  (prod_data),
    .prod_ready (prod_ready),
    .sum_valid  (sum_valid),
    .sum_data   (sum_data),
    .sum_ready  (sum_ready),
    .busy       (busy),
    .overflow   (overflow)
  );

  mult_accumulator #(.ACC_W(33)) dut33 (
    .clk        (clk),
    .reset      (reset),
    .clear      (b_clear),
    .start      (b_start),
    .len        (b_len),
    .prod_valid (b_prod_valid),
    .prod_data  (b_prod_data),
    .prod_ready (b_prod_ready),
    .sum_valid  (b_sum_valid),
    .sum_data   (b_sum_data),
    .sum_ready  (b_sum_ready),
    .busy       (b_busy),
    .overflow   (b_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; start = 1'b0; len = '0;
    prod_valid = 1'b0; prod_data = '0; sum_ready = 1'b0;
    b_clear = 1'b0; b_start = 1'b0; b_len = '0;
    b_prod_valid = 1'b0; b_prod_data = '0; b_sum_ready = 1'b0;

    #3;
    chk("rst_busy", busy, 0);
    chk("rst_prod_ready", prod_ready, 0);
    chk("rst_sum_valid", sum_valid, 0);
    chk("rst_sum_data", sum_data, 0);
    chk("rst_overflow", overflow, 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Block of 4, back-to-back products.
    start = 1'b1; len = 5'd4; sum_ready = 1'b1;
    tick();
    chk("t2_prod_ready", prod_ready, 1);
    chk("t2_busy", busy, 1);
    start = 1'b0; prod_valid = 1'b1; prod_data = 32'd10;
    tick(); prod_data = 32'd20;
    tick(); prod_data = 32'd30;
    tick();
    chk("t2_no_early_valid", sum_valid, 0);
    prod_data = 32'd40;
    tick();
    prod_valid = 1'b0;
    chk("t2_sum_valid", sum_valid, 1);
    chk("t2_sum_data", sum_data, 100);
    chk("t2_overflow", overflow, 0);
    chk("t2_prod_ready_low", prod_ready, 0);
    tick();
    chk("t2_sum_valid_drop", sum_valid, 0);
    chk("t2_idle", busy, 0);

    // Block of 3 with gaps, consumer stalls in HOLD.
    sum_ready = 1'b0; start = 1'b1; len = 5'd3;
    tick();
    start = 1'b0; prod_valid = 1'b1; prod_data = 32'd5;
    tick(); prod_valid = 1'b0; prod_data = 32'd999;
    tick(); prod_valid = 1'b1; prod_data = 32'd6;
    tick(); prod_valid = 1'b0; prod_data = 32'd999;
    tick();
    chk("t3_wait_last", sum_valid, 0);
    prod_valid = 1'b1; prod_data = 32'd7;
    tick();
    prod_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", sum_valid, 1);
      chk("t3_hold_data", sum_data, 18);
      start = (i % 2 == 0); len = 5'd2;
      tick();
    end
    start = 1'b0;
    chk("t3_after_start_pulses", sum_data, 18);
    sum_ready = 1'b1;
    tick();
    chk("t3_idle", busy, 0);

    // Empty block.
    sum_ready = 1'b0; start = 1'b1; len = 5'd0;
    prod_valid = 1'b1; prod_data = 32'd55;
    tick();
    start = 1'b0;
    chk("t4_sum_valid", sum_valid, 1);
    chk("t4_sum_data", sum_data, 0);
    chk("t4_prod_ready", prod_ready, 0);
    tick();
    chk("t4_no_handshake", sum_data, 0);
    prod_valid = 1'b0; sum_ready = 1'b1;
    tick();
    chk("t4_idle", busy, 0);

    // Oversize len clamps to MAX_LEN=16.
    start = 1'b1; len = 5'd20;
    tick();
    start = 1'b0; prod_valid = 1'b1; prod_data = 32'd1;
    for (int i = 0; i < 15; i++) tick();
    chk("clamp_not_done", sum_valid, 0);
    tick();
    prod_valid = 1'b0;
    chk("clamp_done", sum_valid, 1);
    chk("clamp_sum", sum_data, 16);
    tick();

    // Carry out of a 33-bit accumulator.
    b_sum_ready = 1'b0; b_start = 1'b1; b_len = 5'd3;
    tick();
    b_start = 1'b0; b_prod_valid = 1'b1; b_prod_data = 32'hFFFF_FFFF;
    tick(); tick();
    chk("t5_no_ovf_yet", b_overflow, 0);
    tick();
    b_prod_valid = 1'b0;
`ifdef MULT_ACC_SAT_EN
    exp33 = 64'h1_FFFF_FFFF;
`else
    exp33 = 64'h0_FFFF_FFFD;
`endif
    chk("t5_sum_valid", b_sum_valid, 1);
    chk("t5_sum_data", b_sum_data, exp33);
    chk("t5_overflow", b_overflow, 1);
    b_sum_ready = 1'b1;
    tick();
    b_start = 1'b1; b_len = 5'd1;
    tick();
    b_start = 1'b0;
    chk("t5_ovf_cleared_by_start", b_overflow, 0);
    b_prod_valid = 1'b1; b_prod_data = 32'd1;
    tick();
    b_prod_valid = 1'b0;
    chk("t5_next_sum", b_sum_data, 1);
    tick();

    // clear during ACCUM with a product offered.
    sum_ready = 1'b1; start = 1'b1; len = 5'd2;
    tick();
    start = 1'b0; prod_valid = 1'b1; prod_data = 32'd100;
    tick();
    clear = 1'b1; prod_data = 32'd200;
    tick();
    clear = 1'b0; prod_valid = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_prod_ready", prod_ready, 0);
    chk("t6_acc_zero", sum_data, 0);
    start = 1'b1; len = 5'd1;
    tick();
    start = 1'b0; prod_valid = 1'b1; prod_data = 32'd7;
    tick();
    prod_valid = 1'b0;
    chk("t6_sum_valid", sum_valid, 1);
    chk("t6_sum_data", sum_data, 7);
    tick();

    // Async reset after 3 of 5 products.
    sum_ready = 1'b0; start = 1'b1; len = 5'd5;
    tick();
    start = 1'b0; prod_valid = 1'b1; prod_data = 32'd9;
    tick(); tick(); tick();
    prod_valid = 1'b0;
    chk("t1_pre_busy", busy, 1);
    chk("t1_pre_acc", sum_data, 27);
    reset = 1'b0;
    #1;
    chk("t1_busy", busy, 0);
    chk("t1_prod_ready", prod_ready, 0);
    chk("t1_sum_valid", sum_valid, 0);
    chk("t1_sum_data", sum_data, 0);
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("t1_rel_busy", busy, 0);
    chk("t1_rel_prod_ready", prod_ready, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
